aes_out_serializer: RTL and testbench
=====================================

Name: aes_out_serializer

Overview:
- Downstream of the AES encryption core; converts each completed 128-bit ciphertext block into a byte stream, 16 bytes per block, on a valid/ready handshake.
- Holds up to two pending blocks in a 2-entry block FIFO, so the core can deliver the next block while the current one is still being emitted.
- A single shift/count engine drives the byte port and produces no bubble between consecutive blocks.

Parameters:
- BLOCK_W, 128: ciphertext block width in bits; must equal 8*NUM_BYTES.
- NUM_BYTES, 16: bytes per block; byte counter width is clog2(NUM_BYTES).
- MSB_FIRST, 1: 1 emits block[127:120] first; 0 emits block[7:0] first.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- block_in  in  BLOCK_W  ciphertext block from the AES core.
- block_valid  in  1  block_in is valid.
- block_ready  out  1  block FIFO can accept a block this cycle.
- state_out_byte  out  8  current output byte.
- byte_valid  out  1  state_out_byte is valid.
- byte_ready  in  1  consumer accepts the byte.
- last  out  1  marks the final byte of a block; qualified by byte_valid.
- busy  out  1  high when the FIFO is not empty or a block is being sent.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: block_ready=0, byte_valid=0, last=0, busy=0, state_out_byte=0.
  - FIFO count=0, byte counter=0, FSM=IDLE.
  - block_ready rises on the first clk edge after rst deasserts.
- Push: block_valid && block_ready at an edge writes block_in into the FIFO tail.
  - block_ready is registered: next value = (next_fifo_count < 2).
  - block_valid while block_ready=0 is ignored, with no error flag.
- Pop: occurs when the FSM loads the shift register from the FIFO head.
  - Push and pop at the same edge leave the count unchanged, and both take effect.
- FSM IDLE:
  - byte_valid=0.
  - If FIFO is non-empty, pop the head into a 128-bit shift register, clear the byte counter, go to SEND.
  - Latency: a block pushed at edge N into an empty, idle unit gives byte_valid=1 after edge N+1; the first byte appears after 2 edges.
- FSM SEND:
  - byte_valid=1. state_out_byte is the top byte of the shift register (bottom byte if MSB_FIRST=0).
  - last = (counter == NUM_BYTES-1).
  - On byte_valid && byte_ready: shift by 8 bits and increment the counter.
  - On the last-byte handshake:
    - If the FIFO is non-empty (counting a push at the same edge only if it was already committed), pop the next block in the same edge, reset the counter, stay in SEND. Result: zero idle cycles between blocks.
    - Otherwise go to IDLE.
- Backpressure: while byte_valid && !byte_ready, state_out_byte, last and the counter hold stable.
- Counter wrap: the counter never exceeds NUM_BYTES-1 and returns to 0 only by reload.
- busy = (fifo_count != 0) || (FSM == SEND); registered.
- Reset mid-block: the partial block and all queued blocks are discarded. No byte is re-emitted after reset; byte_valid drops asynchronously.
- No combinational path from block_valid to block_ready, or from byte_ready to byte_valid.

Decomposition:
- Shared package aes_pkg holds:
  - constants AES_BLOCK_W=128 and AES_NUM_BYTES=16;
  - typedef aes_block_t = logic [127:0];
  - enum ser_state_t {IDLE, SEND}.
- Sub-module aes_block_fifo2: 2-entry FIFO of aes_block_t.
  - Contents: write/read pointers, 2-bit count, full/empty outputs, async active-high reset.
  - The serializer instantiates it once.
- Top level holds the FSM, shift register and byte counter.

Test Plan:
- Single block: push 0x00112233445566778899AABBCCDDEEFF with byte_ready=1.
  - Expect 16 consecutive bytes 0x00,0x11,…,0xFF.
  - last=1 only on 0xFF; busy falls 1 cycle after the last handshake.
- Backpressure: same block, byte_ready low for 3 cycles at byte 5 (0x55).
  - 0x55 is held stable with byte_valid=1 and the counter frozen; the sequence resumes intact.
- Back-to-back: push block A = all 0xA5, then block B = all 0x3C at the next edge; byte_ready=1.
  - Expect 32 bytes with no byte_valid gap; last pulses on bytes 16 and 32.
- FIFO full: byte_ready=0, push 3 blocks on consecutive cycles.
  - First is loaded into SEND, next two fill the FIFO, block_ready=0 before the 4th attempt.
  - The 4th block is dropped; all 3 accepted blocks are later emitted in order.
- Reset mid-block: assert rst after byte 7 of a block.
  - byte_valid=0 immediately and the FIFO is empty.
  - After release, block_ready=1 one edge later; a new block emits from its byte 0.
- MSB_FIRST=0: the single-block stimulus emits 0xFF first and 0x00 last.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES serializer types and constants.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W   = 128;
  localparam int unsigned AES_NUM_BYTES = 16;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_t;

endpackage

// File: rtl/aes_out_serializer_if.sv
// Block-in / byte-out handshake bundle for the AES output serializer.
interface aes_out_serializer_if
  import aes_pkg::*;
#(
  parameter int unsigned BLOCK_W = AES_BLOCK_W
) ();

  logic [BLOCK_W-1:0] block_in;
  logic               block_valid;
  logic               block_ready;
  logic [7:0]         state_out_byte;
  logic               byte_valid;
  logic               byte_ready;
  logic               last;
  logic               busy;

  modport master (
    output block_in, block_valid, byte_ready,
    input  block_ready, state_out_byte, byte_valid, last, busy
  );

  modport slave (
    input  block_in, block_valid, byte_ready,
    output block_ready, state_out_byte, byte_valid, last, busy
  );

endinterface

// File: rtl/aes_block_fifo2.sv
// Two-entry FIFO of ciphertext blocks; push/pop are ignored when full/empty.
module aes_block_fifo2
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  aes_block_t wdata,
  input  logic       pop,
  output aes_block_t rdata,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  aes_block_t mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       wr_en;
  logic       rd_en;

  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (wr_en) wr_ptr_q <= ~wr_ptr_q;
      if (rd_en) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, wr_en} - {1'b0, rd_en};
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/aes_out_serializer.sv
// Serializes 128-bit AES ciphertext blocks into a byte stream with a 2-block queue.
module aes_out_serializer
  import aes_pkg::*;
#(
  parameter int unsigned BLOCK_W   = AES_BLOCK_W,
  parameter int unsigned NUM_BYTES = AES_NUM_BYTES,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  aes_out_serializer_if.slave bus
);

  localparam int unsigned     CntW    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(NUM_BYTES - 1);

  ser_state_t         state_q, state_d;
  logic [BLOCK_W-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               block_ready_q, block_ready_d;
  logic               busy_q, busy_d;

  logic               push;
  logic               pop;
  logic               fire;
  logic               is_last;
  aes_block_t         fifo_rdata;
  logic [1:0]         fifo_count;
  logic [1:0]         fifo_count_d;
  logic               fifo_full;
  logic               fifo_empty;

  assign push    = bus.block_valid && block_ready_q && !fifo_full;
  assign fire    = (state_q == SEND) && bus.byte_ready;
  assign is_last = (cnt_q == LastIdx);

  aes_block_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (bus.block_in),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        // Reload on the final byte only from blocks already queued, so no bubble.
        if (fire && is_last) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      shreg_d = fifo_rdata;
      cnt_d   = '0;
    end else if (fire) begin
      shreg_d = MSB_FIRST ? (shreg_q << 8) : (shreg_q >> 8);
      if (!is_last) cnt_d = cnt_q + CntW'(1);
    end

    fifo_count_d  = fifo_count + {1'b0, push} - {1'b0, pop};
    block_ready_d = (fifo_count_d < 2'd2);
    busy_d        = (fifo_count_d != 2'd0) || (state_d == SEND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      cnt_q         <= '0;
      block_ready_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      block_ready_q <= block_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.block_ready    = block_ready_q;
  assign bus.byte_valid     = (state_q == SEND);
  assign bus.last           = (state_q == SEND) && is_last;
  assign bus.busy           = busy_q;
  assign bus.state_out_byte = MSB_FIRST ? shreg_q[BLOCK_W-1 -: 8] : shreg_q[7:0];

endmodule

// File: tb/tb_aes_out_serializer.sv
// Scoreboard bench for aes_out_serializer: MSB-first and LSB-first instances.
module tb_aes_out_serializer;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_out_serializer_if bus_m ();
  aes_out_serializer_if bus_l ();

  aes_out_serializer #(.BLOCK_W(128), .NUM_BYTES(16), .MSB_FIRST(1'b1)) u_msb (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  aes_out_serializer #(.BLOCK_W(128), .NUM_BYTES(16), .MSB_FIRST(1'b0)) u_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  bit         last_q [$];

  localparam aes_block_t Blk0 = 128'h00112233445566778899AABBCCDDEEFF;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input aes_block_t blk, input bit msb);
    for (int i = 0; i < 16; i++) begin
      if (msb) exp_q.push_back(blk[8*(15-i) +: 8]);
      else     exp_q.push_back(blk[8*i +: 8]);
      last_q.push_back(i == 15);
    end
  endtask

  task automatic push_block(input aes_block_t blk, output bit acc);
    bus_m.block_in    = blk;
    bus_m.block_valid = 1'b1;
    acc = bus_m.block_ready;
    if (acc) sb_push(blk, 1'b1);
    step();
    bus_m.block_valid = 1'b0;
  endtask

  // Consume bytes from the MSB instance against the scoreboard.
  task automatic drain(input int stall_idx, input int stall_len, input int max_bytes,
                       input bit no_gap);
    int idx = 0;
    int guard = 0;
    bit started = 1'b0;
    bus_m.byte_ready = 1'b1;
    while (exp_q.size() != 0 && idx < max_bytes && guard < 500) begin
      guard++;
      if (bus_m.byte_valid && idx == stall_idx && stall_len > 0) begin
        bus_m.byte_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          step();
          checks++;
          if (bus_m.byte_valid !== 1'b1 || bus_m.state_out_byte !== exp_q[0] ||
              bus_m.last !== last_q[0]) begin
            errors++;
            $display("FAIL stall_hold k=%0d valid=%b byte=%h last=%b required valid=1 byte=%h last=%b",
                     k, bus_m.byte_valid, bus_m.state_out_byte, bus_m.last, exp_q[0], last_q[0]);
          end
        end
        bus_m.byte_ready = 1'b1;
        stall_len = 0;
      end
      if (bus_m.byte_valid) begin
        checks++;
        if (bus_m.state_out_byte !== exp_q[0] || bus_m.last !== last_q[0]) begin
          errors++;
          $display("FAIL byte_seq idx=%0d byte=%h last=%b required byte=%h last=%b",
                   idx, bus_m.state_out_byte, bus_m.last, exp_q[0], last_q[0]);
        end
        void'(exp_q.pop_front());
        void'(last_q.pop_front());
        idx++;
        started = 1'b1;
      end else if (started && no_gap) begin
        checks++;
        errors++;
        $display("FAIL no_gap idx=%0d byte_valid=0 required 1", idx);
      end
      step();
    end
    if (guard >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout remaining=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({bus_m.block_ready, bus_m.byte_valid, bus_m.last, bus_m.busy} !== 4'b0000 ||
        bus_m.state_out_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs rdy/val/last/busy=%b byte=%h required 0000 00",
               {bus_m.block_ready, bus_m.byte_valid, bus_m.last, bus_m.busy},
               bus_m.state_out_byte);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus_m.block_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge got=%b required 0", bus_m.block_ready);
    end
    step();
    checks++;
    if (bus_m.block_ready !== 1'b1 || bus_m.byte_valid !== 1'b0 || bus_m.busy !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_release rdy=%b val=%b busy=%b required 1 0 0",
               bus_m.block_ready, bus_m.byte_valid, bus_m.busy);
    end
  endtask

  task automatic test_single();
    bit acc;
    bus_m.byte_ready = 1'b1;
    push_block(Blk0, acc);
    checks++;
    if (acc !== 1'b1 || bus_m.byte_valid !== 1'b0 || bus_m.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_latency1 acc=%b val=%b busy=%b required 1 0 1",
               acc, bus_m.byte_valid, bus_m.busy);
    end
    step();
    checks++;
    if (bus_m.byte_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency2 val=%b required 1", bus_m.byte_valid);
    end
    drain(-1, 0, 16, 1'b1);
    checks++;
    if (bus_m.byte_valid !== 1'b0 || bus_m.busy !== 1'b0 || bus_m.last !== 1'b0) begin
      errors++;
      $display("FAIL single_end val=%b busy=%b last=%b required 0 0 0",
               bus_m.byte_valid, bus_m.busy, bus_m.last);
    end
  endtask

  task automatic test_backpressure();
    bit acc;
    push_block(Blk0, acc);
    checks++;
    if (acc !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept got=%b required 1", acc);
    end
    drain(5, 3, 16, 1'b0);
    checks++;
    if (bus_m.byte_valid !== 1'b0 || bus_m.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_end val=%b busy=%b required 0 0", bus_m.byte_valid, bus_m.busy);
    end
  endtask

  task automatic test_back_to_back();
    bit acc_a, acc_b;
    push_block({16{8'hA5}}, acc_a);
    push_block({16{8'h3C}}, acc_b);
    checks++;
    if (acc_a !== 1'b1 || acc_b !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept a=%b b=%b required 1 1", acc_a, acc_b);
    end
    drain(-1, 0, 32, 1'b1);
    checks++;
    if (bus_m.byte_valid !== 1'b0 || bus_m.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end val=%b busy=%b required 0 0", bus_m.byte_valid, bus_m.busy);
    end
  endtask

  task automatic test_fifo_full();
    aes_block_t blk;
    bit acc [4];
    bus_m.byte_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      push_block(blk, acc[i]);
    end
    checks++;
    if (acc[0] !== 1'b1 || acc[1] !== 1'b1 || acc[2] !== 1'b1 || acc[3] !== 1'b0) begin
      errors++;
      $display("FAIL full_accept pattern=%b%b%b%b required 1110", acc[0], acc[1], acc[2], acc[3]);
    end
    checks++;
    if (bus_m.block_ready !== 1'b0 || bus_m.busy !== 1'b1 || bus_m.byte_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_status rdy=%b busy=%b val=%b required 0 1 1",
               bus_m.block_ready, bus_m.busy, bus_m.byte_valid);
    end
    drain(-1, 0, 48, 1'b1);
    repeat (3) step();
    checks++;
    if (bus_m.byte_valid !== 1'b0 || bus_m.busy !== 1'b0) begin
      errors++;
      $display("FAIL full_dropped val=%b busy=%b required 0 0", bus_m.byte_valid, bus_m.busy);
    end
  endtask

  task automatic test_reset_mid();
    bit acc_x, acc_y, acc_z;
    aes_block_t blk_z;
    bus_m.byte_ready = 1'b1;
    push_block(Blk0, acc_x);
    push_block({16{8'hEE}}, acc_y);
    drain(-1, 0, 8, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (bus_m.byte_valid !== 1'b0 || bus_m.last !== 1'b0 || bus_m.busy !== 1'b0 ||
        bus_m.block_ready !== 1'b0 || bus_m.state_out_byte !== 8'h00) begin
      errors++;
      $display("FAIL midrst_async val=%b last=%b busy=%b rdy=%b byte=%h required 0 0 0 0 00",
               bus_m.byte_valid, bus_m.last, bus_m.busy, bus_m.block_ready,
               bus_m.state_out_byte);
    end
    exp_q.delete();
    last_q.delete();
    step();
    rst = 1'b0;
    step();
    checks++;
    if (bus_m.block_ready !== 1'b1 || bus_m.byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_release rdy=%b val=%b required 1 0",
               bus_m.block_ready, bus_m.byte_valid);
    end
    repeat (3) step();
    checks++;
    if (bus_m.byte_valid !== 1'b0 || bus_m.busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_flushed val=%b busy=%b required 0 0", bus_m.byte_valid, bus_m.busy);
    end
    blk_z = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
    push_block(blk_z, acc_z);
    checks++;
    if (acc_x !== 1'b1 || acc_y !== 1'b1 || acc_z !== 1'b1) begin
      errors++;
      $display("FAIL midrst_accept x=%b y=%b z=%b required 1 1 1", acc_x, acc_y, acc_z);
    end
    step();
    drain(-1, 0, 16, 1'b1);
  endtask

  task automatic test_lsb_first();
    int guard = 0;
    bus_l.byte_ready  = 1'b1;
    bus_l.block_in    = Blk0;
    bus_l.block_valid = 1'b1;
    checks++;
    if (bus_l.block_ready !== 1'b1) begin
      errors++;
      $display("FAIL lsb_ready got=%b required 1", bus_l.block_ready);
    end else begin
      sb_push(Blk0, 1'b0);
    end
    step();
    bus_l.block_valid = 1'b0;
    while (exp_q.size() != 0 && guard < 100) begin
      guard++;
      if (bus_l.byte_valid) begin
        checks++;
        if (bus_l.state_out_byte !== exp_q[0] || bus_l.last !== last_q[0]) begin
          errors++;
          $display("FAIL lsb_seq byte=%h last=%b required byte=%h last=%b",
                   bus_l.state_out_byte, bus_l.last, exp_q[0], last_q[0]);
        end
        void'(exp_q.pop_front());
        void'(last_q.pop_front());
      end
      step();
    end
    checks++;
    if (guard >= 100 || bus_l.byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL lsb_end remaining=%0d val=%b required 0 0", exp_q.size(), bus_l.byte_valid);
    end
  endtask

  initial begin
    bus_m.block_in    = '0;
    bus_m.block_valid = 1'b0;
    bus_m.byte_ready  = 1'b0;
    bus_l.block_in    = '0;
    bus_l.block_valid = 1'b0;
    bus_l.byte_ready  = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid();
    test_lsb_first();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
